// File: rtl/audio_sample_fifo.sv
// Stereo sample FIFO feeding i2s_unit: stores {left,right} pairs, pops one pair per req pulse
// with a one-cycle tick, inserts silence on underrun and flushes when play mode drops.
module audio_sample_fifo #(
    parameter int DATA_W   = 24,
    parameter int DEPTH    = 8,
    parameter int LOW_MARK = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       play_in,
    input  logic                       wr_in,
    input  logic [DATA_W-1:0]          audio0_wdata,
    input  logic [DATA_W-1:0]          audio1_wdata,
    output logic                       wr_ready_out,
    input  logic                       req_in,
    output logic [DATA_W-1:0]          audio0_out,
    output logic [DATA_W-1:0]          audio1_out,
    output logic                       tick_out,
    output logic [$clog2(DEPTH+1)-1:0] level_out,
    output logic                       need_out,
    output logic                       underrun_out
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] LOW_LVL  = LW'(LOW_MARK);

    logic [DATA_W-1:0] mem0 [DEPTH];
    logic [DATA_W-1:0] mem1 [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              play_q;
    logic              flush;
    logic              pop;
    logic              pop_data;
    logic              push;

    assign wr_ready_out = (level_out != FULL_LVL);
    assign need_out     = (level_out < LOW_LVL);

    // Falling edge of play discards everything, including a write in the same cycle.
    assign flush    = play_q & ~play_in;
    assign pop      = req_in & play_in;
    assign pop_data = pop & (level_out != '0);
    assign push     = wr_in & wr_ready_out & ~flush;

    // Sample storage carries no reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem0[wr_ptr] <= audio0_wdata;
            mem1[wr_ptr] <= audio1_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level_out    <= '0;
            audio0_out   <= '0;
            audio1_out   <= '0;
            tick_out     <= 1'b0;
            underrun_out <= 1'b0;
            play_q       <= 1'b0;
        end else begin
            play_q   <= play_in;
            tick_out <= pop;
            if (flush) begin
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                level_out    <= '0;
                audio0_out   <= '0;
                audio1_out   <= '0;
                underrun_out <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop_data) begin
                    rd_ptr     <= rd_ptr + PW'(1);
                    audio0_out <= mem0[rd_ptr];
                    audio1_out <= mem1[rd_ptr];
                end else if (pop) begin
                    audio0_out   <= '0;
                    audio1_out   <= '0;
                    underrun_out <= 1'b1;
                end
                case ({push, pop_data})
                    2'b10:   level_out <= level_out + LW'(1);
                    2'b01:   level_out <= level_out - LW'(1);
                    default: level_out <= level_out;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed bench for audio_sample_fifo with hand-computed expectations (DEPTH=8, LOW_MARK=2).
module tb_audio_sample_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        play_in = 1'b0;
    logic        wr_in = 1'b0;
    logic [23:0] audio0_wdata = '0;
    logic [23:0] audio1_wdata = '0;
    logic        wr_ready_out;
    logic        req_in = 1'b0;
    logic [23:0] audio0_out;
    logic [23:0] audio1_out;
    logic        tick_out;
    logic [3:0]  level_out;
    logic        need_out;
    logic        underrun_out;

    int checks = 0;
    int errors = 0;

    audio_sample_fifo #(.DATA_W(24), .DEPTH(8), .LOW_MARK(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .play_in      (play_in),
        .wr_in        (wr_in),
        .audio0_wdata (audio0_wdata),
        .audio1_wdata (audio1_wdata),
        .wr_ready_out (wr_ready_out),
        .req_in       (req_in),
        .audio0_out   (audio0_out),
        .audio1_out   (audio1_out),
        .tick_out     (tick_out),
        .level_out    (level_out),
        .need_out     (need_out),
        .underrun_out (underrun_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic en, input logic [23:0] l, input logic [23:0] r);
        wr_in        = en;
        audio0_wdata = l;
        audio1_wdata = r;
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_level", 32'(level_out), 32'd0);
        chk("rst_ready", 32'(wr_ready_out), 32'd1);
        chk("rst_need", 32'(need_out), 32'd1);
        chk("rst_tick", 32'(tick_out), 32'd0);
        chk("rst_under", 32'(underrun_out), 32'd0);
        chk("rst_out0", 32'(audio0_out), 32'd0);
        step();
        rst = 1'b0;
        play_in = 1'b1;
        step();

        // 1: single write then pop
        set_wr(1'b1, 24'h111111, 24'h222222);
        step();
        set_wr(1'b0, '0, '0);
        chk("t1_level1", 32'(level_out), 32'd1);
        chk("t1_need", 32'(need_out), 32'd1);
        req_in = 1'b1;
        step();
        req_in = 1'b0;
        chk("t1_tick", 32'(tick_out), 32'd1);
        chk("t1_out0", 32'(audio0_out), 32'h111111);
        chk("t1_out1", 32'(audio1_out), 32'h222222);
        chk("t1_level0", 32'(level_out), 32'd0);
        step();
        chk("t1_tick_low", 32'(tick_out), 32'd0);
        chk("t1_hold", 32'(audio0_out), 32'h111111);

        // 2: fill to full, overflow dropped, drain in order
        for (int i = 0; i < 8; i++) begin
            set_wr(1'b1, 24'h100000 + 24'(i), 24'h200000 + 24'(i));
            step();
        end
        chk("t2_level8", 32'(level_out), 32'd8);
        chk("t2_ready0", 32'(wr_ready_out), 32'd0);
        chk("t2_need0", 32'(need_out), 32'd0);
        set_wr(1'b1, 24'hDEAD00, 24'hDEAD01);
        step();
        set_wr(1'b0, '0, '0);
        chk("t2_drop", 32'(level_out), 32'd8);
        req_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t2_tick", 32'(tick_out), 32'd1);
            chk("t2_out0", 32'(audio0_out), 32'h100000 + 32'(i));
            chk("t2_out1", 32'(audio1_out), 32'h200000 + 32'(i));
            chk("t2_level", 32'(level_out), 32'(7 - i));
        end
        req_in = 1'b0;
        chk("t2_ready1", 32'(wr_ready_out), 32'd1);

        // 3: empty pop inserts silence, underrun sticks through refill
        req_in = 1'b1;
        step();
        req_in = 1'b0;
        chk("t3_tick", 32'(tick_out), 32'd1);
        chk("t3_out0", 32'(audio0_out), 32'd0);
        chk("t3_out1", 32'(audio1_out), 32'd0);
        chk("t3_under", 32'(underrun_out), 32'd1);
        chk("t3_level", 32'(level_out), 32'd0);
        set_wr(1'b1, 24'h300001, 24'h400001);
        step();
        chk("t3_under_refill", 32'(underrun_out), 32'd1);

        // 4: simultaneous write+pop at level 3
        set_wr(1'b1, 24'h300002, 24'h400002);
        step();
        set_wr(1'b1, 24'h300003, 24'h400003);
        step();
        chk("t4_level3", 32'(level_out), 32'd3);
        set_wr(1'b1, 24'h300004, 24'h400004);
        req_in = 1'b1;
        step();
        set_wr(1'b0, '0, '0);
        chk("t4_level_same", 32'(level_out), 32'd3);
        chk("t4_oldest", 32'(audio0_out), 32'h300001);
        for (int i = 2; i <= 4; i++) begin
            step();
            chk("t4_order0", 32'(audio0_out), 32'h300000 + 32'(i));
            chk("t4_order1", 32'(audio1_out), 32'h400000 + 32'(i));
        end
        req_in = 1'b0;
        chk("t4_empty", 32'(level_out), 32'd0);
        chk("t4_under", 32'(underrun_out), 32'd1);

        // 5: stop flush, write in edge cycle discarded, req ignored while stopped
        for (int i = 0; i < 5; i++) begin
            set_wr(1'b1, 24'h500000 + 24'(i), 24'h600000 + 24'(i));
            step();
        end
        set_wr(1'b0, '0, '0);
        chk("t5_level5", 32'(level_out), 32'd5);
        play_in = 1'b0;
        set_wr(1'b1, 24'h5A5A5A, 24'h6A6A6A);
        step();
        set_wr(1'b0, '0, '0);
        chk("t5_level0", 32'(level_out), 32'd0);
        chk("t5_out0", 32'(audio0_out), 32'd0);
        chk("t5_out1", 32'(audio1_out), 32'd0);
        chk("t5_under", 32'(underrun_out), 32'd0);
        req_in = 1'b1;
        step();
        req_in = 1'b0;
        chk("t5_notick", 32'(tick_out), 32'd0);
        chk("t5_level_stop", 32'(level_out), 32'd0);

        // 6: pointer wrap with interleaved writes and pops
        play_in = 1'b1;
        set_wr(1'b1, 24'h700000, 24'h800000);
        step();
        for (int i = 0; i < 20; i++) begin
            set_wr(1'b1, 24'h700000 + 24'(i + 1), 24'h800000 + 24'(i + 1));
            step();
            set_wr(1'b0, '0, '0);
            chk("t6_need_l2", 32'(need_out), 32'd0);
            req_in = 1'b1;
            step();
            req_in = 1'b0;
            chk("t6_out0", 32'(audio0_out), 32'h700000 + 32'(i));
            chk("t6_out1", 32'(audio1_out), 32'h800000 + 32'(i));
            chk("t6_need_l1", 32'(need_out), 32'd1);
        end
        req_in = 1'b1;
        step();
        req_in = 1'b0;
        chk("t6_last", 32'(audio0_out), 32'h700014);
        chk("t6_level0", 32'(level_out), 32'd0);

        // Asynchronous reset mid-transfer
        set_wr(1'b1, 24'h900000, 24'hA00000);
        step();
        set_wr(1'b0, '0, '0);
        req_in = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("ar_level", 32'(level_out), 32'd0);
        chk("ar_tick", 32'(tick_out), 32'd0);
        req_in = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("ar_notick", 32'(tick_out), 32'd0);
        chk("ar_out0", 32'(audio0_out), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
